// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings and MMIO map for the CPU memory stage
package cpu_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_src_e;

    localparam logic [31:0] MMIO_BASE_ADDR = 32'h4000_0000;

    // Word index of each peripheral register within the MMIO window
    localparam logic [2:0] MMIO_TH   = 3'd0;
    localparam logic [2:0] MMIO_TL   = 3'd1;
    localparam logic [2:0] MMIO_TCON = 3'd2;
    localparam logic [2:0] MMIO_LED  = 3'd3;
    localparam logic [2:0] MMIO_SW   = 3'd4;
    localparam logic [2:0] MMIO_DIGI = 3'd5;

    localparam int TCON_EN  = 0;
    localparam int TCON_IE  = 1;
    localparam int TCON_IRQ = 2;

    localparam logic [31:0] TL_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer_periph.sv
// rtl/mmio_timer_periph.sv - timer, LED, 7-seg and switch peripheral registers
module mmio_timer_periph
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  reg_idx,
    input  logic [31:0] wr_data,
    input  logic [7:0]  switches,
    output logic [31:0] rd_data,
    output logic [7:0]  leds,
    output logic [11:0] digits,
    output logic        irq
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic        timer_store;

    assign timer_store = wr_en && (reg_idx == MMIO_TH || reg_idx == MMIO_TL ||
                                   reg_idx == MMIO_TCON);

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;
        // A software store to any timer register suppresses that cycle's tick
        if (!timer_store && tcon_q[TCON_EN]) begin
            if (tl_q == TL_MAX) begin
                tl_d = th_q;
                if (tcon_q[TCON_IE]) begin
                    tcon_d[TCON_IRQ] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        if (wr_en) begin
            case (reg_idx)
                MMIO_TH:   th_d   = wr_data;
                MMIO_TL:   tl_d   = wr_data;
                MMIO_TCON: tcon_d = wr_data[2:0];
                MMIO_LED:  led_d  = wr_data[7:0];
                MMIO_DIGI: digi_d = wr_data[11:0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            led_q     <= '0;
            digi_q    <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            led_q     <= led_d;
            digi_q    <= digi_d;
            sw_meta_q <= switches;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_idx)
            MMIO_TH:   rd_data = th_q;
            MMIO_TL:   rd_data = tl_q;
            MMIO_TCON: rd_data = {29'd0, tcon_q};
            MMIO_LED:  rd_data = {24'd0, led_q};
            MMIO_SW:   rd_data = {24'd0, sw_sync_q};
            MMIO_DIGI: rd_data = {20'd0, digi_q};
            default:   rd_data = '0;
        endcase
    end

    assign leds   = led_q;
    assign digits = digi_q;
    assign irq    = tcon_q[TCON_IE] & tcon_q[TCON_IRQ];

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access stage and MEM/WB pipeline register
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int          RAM_WORDS = 256,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic        reg_wr_in,
    input  logic [1:0]  reg_src_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] alu_out_in,
    input  logic [31:0] store_data_in,
    input  logic [31:0] pc_add4_in,
    input  logic [7:0]  switches,
    output logic        reg_wr_out,
    output logic [4:0]  rd_out,
    output logic [31:0] wb_data,
    output logic [31:0] fwd_data,
    output logic [7:0]  leds,
    output logic [11:0] digits,
    output logic        irq
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram_q [RAM_WORDS];
    logic [29:0]   word_idx;
    logic [AW-1:0] ram_addr;
    logic          is_mmio, ram_hit, mmio_hit;
    logic [31:0]   mmio_rdata, load_data;
    logic          reg_wr_q, reg_wr_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   wb_q, wb_d;
    logic          unused_ok;

    assign word_idx = alu_out_in[31:2];
    assign ram_addr = word_idx[AW-1:0];
    assign is_mmio  = alu_out_in[31:28] == MMIO_BASE[31:28];
    assign ram_hit  = !is_mmio && ({2'b00, word_idx} < 32'(RAM_WORDS));
    // Only the first eight words of the MMIO window decode to registers
    assign mmio_hit = is_mmio && (alu_out_in[27:5] == '0);

    always_ff @(posedge clk) begin
        if (!rst && mem_wr_en && ram_hit) begin
            ram_q[ram_addr] <= store_data_in;
        end
    end

    mmio_timer_periph u_periph (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (mem_wr_en && mmio_hit),
        .reg_idx  (alu_out_in[4:2]),
        .wr_data  (store_data_in),
        .switches (switches),
        .rd_data  (mmio_rdata),
        .leds     (leds),
        .digits   (digits),
        .irq      (irq)
    );

    always_comb begin
        load_data = '0;
        if (ram_hit) begin
            load_data = ram_q[ram_addr];
        end else if (mmio_hit) begin
            load_data = mmio_rdata;
        end
    end

    always_comb begin
        fwd_data = alu_out_in;
        case (reg_src_in)
            WB_PC4:  fwd_data = pc_add4_in;
            WB_MEM:  fwd_data = load_data;
            default: fwd_data = alu_out_in;
        endcase
    end

    always_comb begin
        reg_wr_d = reg_wr_in;
        rd_d     = rd_in;
        wb_d     = fwd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wr_q <= 1'b0;
            rd_q     <= '0;
            wb_q     <= '0;
        end else begin
            reg_wr_q <= reg_wr_d;
            rd_q     <= rd_d;
            wb_q     <= wb_d;
        end
    end

    assign reg_wr_out = reg_wr_q;
    assign rd_out     = rd_q;
    assign wb_data    = wb_q;

    assign unused_ok = ^{mem_rd_en, alu_out_in[1:0]};

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, mem_rd_en, mem_wr_en, reg_wr_in;
    logic [1:0]  reg_src_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_out_in, store_data_in, pc_add4_in;
    logic [7:0]  switches;
    logic        reg_wr_out;
    logic [4:0]  rd_out;
    logic [31:0] wb_data, fwd_data;
    logic [7:0]  leds;
    logic [11:0] digits;
    logic        irq;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .reg_wr_in(reg_wr_in), .reg_src_in(reg_src_in), .rd_in(rd_in),
        .alu_out_in(alu_out_in), .store_data_in(store_data_in),
        .pc_add4_in(pc_add4_in), .switches(switches), .reg_wr_out(reg_wr_out),
        .rd_out(rd_out), .wb_data(wb_data), .fwd_data(fwd_data), .leds(leds),
        .digits(digits), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_fwd;
    logic [7:0]  sw_val = 8'h00;

    // Reference model state
    logic [31:0] m_ram [256];
    logic [31:0] m_th = 0, m_tl = 0, m_wb = 0;
    logic [2:0]  m_tcon = 0;
    logic [7:0]  m_led = 0;
    logic [11:0] m_digi = 0;
    logic [7:0]  m_swq [$] = '{8'h00, 8'h00};
    logic        m_rw = 0;
    logic [4:0]  m_rd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] a);
        logic [31:0] off;
        if (a[31:28] == 4'h4) begin
            off = {4'h0, a[27:0]} & 32'hFFFF_FFFC;
            case (off)
                32'h00:  return m_th;
                32'h04:  return m_tl;
                32'h08:  return 32'(m_tcon);
                32'h0C:  return 32'(m_led);
                32'h10:  return 32'(m_swq[1]);
                32'h14:  return 32'(m_digi);
                default: return 0;
            endcase
        end
        if ((a >> 2) < 256) return m_ram[a[9:2]];
        return 0;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [1:0] src, input logic [31:0] a, input logic [31:0] pc);
        if (src == 2'b10) return pc;
        if (src == 2'b01) return m_load(a);
        return a;
    endfunction

    function automatic void m_edge(input logic r, input logic wre, input logic rw, input logic [4:0] rd,
                                   input logic [31:0] a, input logic [31:0] sd, input logic [31:0] fwd);
        logic [31:0] off;
        logic        mm, tstore;
        if (r) begin
            m_wb = 0; m_rw = 0; m_rd = 0;
            m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0;
            m_swq = '{8'h00, 8'h00};
            return;
        end
        m_wb = fwd; m_rw = rw; m_rd = rd;
        m_swq.push_front(switches);
        void'(m_swq.pop_back());
        mm     = (a[31:28] == 4'h4) && (a[27:0] < 28'h20);
        off    = {4'h0, a[27:0]} & 32'hFFFF_FFFC;
        tstore = wre && mm && (off <= 32'h08);
        if (!tstore && m_tcon[0]) begin
            if (m_tl == 32'hFFFF_FFFF) begin
                m_tl = m_th;
                if (m_tcon[1]) m_tcon[2] = 1'b1;
            end else begin
                m_tl = m_tl + 1;
            end
        end
        if (wre) begin
            if (mm) begin
                case (off)
                    32'h00: m_th = sd;
                    32'h04: m_tl = sd;
                    32'h08: m_tcon = sd[2:0];
                    32'h0C: m_led = sd[7:0];
                    32'h14: m_digi = sd[11:0];
                    default: ;
                endcase
            end else if (a[31:28] != 4'h4 && (a >> 2) < 256) begin
                m_ram[a[9:2]] = sd;
            end
        end
    endfunction

    task automatic step(input logic r, input logic rde, input logic wre, input logic rw,
                        input logic [1:0] src, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] pc);
        logic [31:0] ef;
        @(negedge clk);
        rst = r; mem_rd_en = rde; mem_wr_en = wre; reg_wr_in = rw; reg_src_in = src;
        rd_in = rd; alu_out_in = a; store_data_in = sd; pc_add4_in = pc; switches = sw_val;
        #1;
        ef = m_fwd(src, a, pc);
        last_fwd = fwd_data;
        chk("fwd", fwd_data, ef);
        @(posedge clk);
        m_edge(r, wre, rw, rd, a, sd, ef);
        #1;
        chk("wb", wb_data, m_wb);
        chk("rd_out", 32'(rd_out), 32'(m_rd));
        chk("reg_wr", 32'(reg_wr_out), 32'(m_rw));
        chk("leds", 32'(leds), 32'(m_led));
        chk("digits", 32'(digits), 32'(m_digi));
        chk("irq", 32'(irq), 32'(m_tcon[1] & m_tcon[2]));
    endtask

    typedef struct {
        logic [31:0] r, rde, wre, rw, src, rd, alu, sd, pc, ef, ew, erw, erd;
    } vec_t;

    initial begin
        vec_t tbl[$];
        logic [31:0] a, sd;
        logic [1:0]  src;
        logic        wre, r;

        tbl.push_back('{1, 0, 0, 1, 0, 3, 'h1234, 0, 0, 'h1234, 0, 0, 0});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 'h10, 'hDEADBEEF, 0, 'h10, 'h10, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 5, 'h13, 0, 0, 'hDEADBEEF, 'hDEADBEEF, 1, 5});
        tbl.push_back('{0, 0, 0, 1, 2, 9, 'h55, 0, 'h104, 'h104, 'h104, 1, 9});
        tbl.push_back('{0, 0, 0, 1, 3, 10, 'h77, 0, 'h999, 'h77, 'h77, 1, 10});
        tbl.push_back('{0, 1, 0, 1, 1, 11, 'h400, 0, 0, 0, 0, 1, 11});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 'h4000000C, 'h1C3, 0, 'h4000000C, 'h4000000C, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 12, 'h4000000C, 0, 0, 'hC3, 'hC3, 1, 12});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 'h40000014, 'hABCDE, 0, 'h40000014, 'h40000014, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 13, 'h40000016, 0, 0, 'hCDE, 'hCDE, 1, 13});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 'h40000018, 'hFFFF, 0, 'h40000018, 'h40000018, 0, 0});
        tbl.push_back('{0, 1, 0, 1, 1, 14, 'h40000018, 0, 0, 0, 0, 1, 14});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 'h20, 'h1111, 0, 'h20, 'h20, 0, 0});
        tbl.push_back('{0, 1, 1, 1, 1, 15, 'h20, 'h2222, 0, 'h1111, 'h1111, 1, 15});
        tbl.push_back('{0, 1, 0, 1, 1, 16, 'h20, 0, 0, 'h2222, 'h2222, 1, 16});
        tbl.push_back('{0, 1, 0, 1, 1, 17, 'h80000010, 0, 0, 0, 0, 1, 17});
        tbl.push_back('{0, 1, 0, 1, 1, 18, 'h40000010, 0, 0, 0, 0, 1, 18});

        switches = 8'h00;
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 256; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 32'(i * 4), 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r[0], tbl[i].rde[0], tbl[i].wre[0], tbl[i].rw[0], tbl[i].src[1:0],
                 tbl[i].rd[4:0], tbl[i].alu, tbl[i].sd, tbl[i].pc);
            chk($sformatf("tbl%0d_fwd", i), last_fwd, tbl[i].ef);
            chk($sformatf("tbl%0d_wb", i), wb_data, tbl[i].ew);
            chk($sformatf("tbl%0d_rw", i), 32'(reg_wr_out), tbl[i].erw);
            chk($sformatf("tbl%0d_rd", i), 32'(rd_out), tbl[i].erd);
        end

        // Timer overflow with reload and interrupt
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 32'h40000000, 32'hFFFF_FFF0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 32'h40000004, 32'hFFFF_FFFE, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 32'h40000008, 32'h3, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        chk("ovf_irq", 32'(irq), 32'h1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd1, 32'h40000004, 32'h0, 32'h0);
        chk("ovf_tl", last_fwd, 32'hFFFF_FFF0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd1, 32'h40000008, 32'h0, 32'h0);
        chk("ovf_tcon", last_fwd, 32'h7);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 32'h40000008, 32'h3, 32'h0);
        chk("irq_clear", 32'(irq), 32'h0);

        // Store to TL beats the concurrent increment
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 32'h40000004, 32'h100, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd2, 32'h40000004, 32'h0, 32'h0);
        chk("collide_tl", last_fwd, 32'h100);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 32'h40000008, 32'h0, 32'h0);

        // Switch synchronizer latency
        sw_val = 8'hA5;
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd3, 32'h40000010, 32'h0, 32'h0);
        chk("sw_c1", last_fwd, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd3, 32'h40000010, 32'h0, 32'h0);
        chk("sw_c2", last_fwd, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd3, 32'h40000010, 32'h0, 32'h0);
        chk("sw_c3", last_fwd, 32'hA5);
        chk("sw_wb_prev", wb_data, 32'hA5);

        // Reset mid-stream discards MMIO and RAM stores, keeps RAM contents
        step(1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 5'd7, 32'h40000008, 32'h3, 32'h0);
        chk("rst_leds", 32'(leds), 32'h0);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_wb", wb_data, 32'h0);
        chk("rst_rd", 32'(rd_out), 32'h0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 32'h10, 32'h0BAD, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd4, 32'h40000008, 32'h0, 32'h0);
        chk("rst_tcon", last_fwd, 32'h0);
        chk("rst_irq2", 32'(irq), 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd4, 32'h40000010, 32'h0, 32'h0);
        chk("rst_sw", last_fwd, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 5'd4, 32'h10, 32'h0, 32'h0);
        chk("ram_kept", last_fwd, 32'hDEADBEEF);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = {22'd0, 8'($urandom), 2'($urandom)};
                5:             a = ($urandom_range(0, 1) != 0) ? (32'h400 + 32'($urandom_range(0, 4095)))
                                                               : {4'h8, 28'($urandom)};
                6, 7, 8:       a = 32'h40000000 | 32'($urandom_range(0, 31));
                default:       a = {4'h4, 28'($urandom)};
            endcase
            sd  = ($urandom_range(0, 1) != 0) ? $urandom : 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
            src = 2'($urandom);
            wre = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) sw_val = 8'($urandom);
            step(r, src == 2'b01, wre, 1'($urandom), src, 5'($urandom), a, sd, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
